// File: rtl/i2s_tx_if.sv
// Sample stream into the I2S transmitter: din/din_vld come from the producer,
// and din_rdy goes back to it.
interface i2s_tx_if #(
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0] din;
  logic              din_vld;
  logic              din_rdy;

  modport master (output din, output din_vld, input din_rdy);
  modport slave  (input din, input din_vld, output din_rdy);
endinterface

// File: rtl/i2s_tx.sv
// I2S master transmitter: each accepted sample is sent in one mono-duplicated stereo frame.
// Defining I2S_TX_UNDERRUN_HOLD_EN makes an underrun frame repeat the previous sample instead of sending zeros.
module i2s_tx #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned SLOT_W  = 16,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic    clk,
  input  logic    rst,
  i2s_tx_if.slave src,
  output logic    sck,
  output logic    ws,
  output logic    sd,
  output logic    underrun
);
  localparam int unsigned FRAME = 2 * SLOT_W;
  localparam int unsigned P_W   = $clog2(FRAME);
  localparam int unsigned D_W   = $clog2(CLK_DIV);
  localparam logic [DATA_W-1:0] MSB = {1'b1, {(DATA_W-1){1'b0}}};

  logic [D_W-1:0]    div_cnt;
  logic [P_W-1:0]    p, p_nxt, k_nxt;
  logic              hold_full;
  logic [DATA_W-1:0] hold_data, shreg, fill, load_smp, cur_smp, sel;
  logic              tick, fall, load, accept, ws_nxt, bit_nxt;

`ifdef I2S_TX_UNDERRUN_HOLD_EN
  logic [DATA_W-1:0] last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= '0;
    end else if (load) begin
      last <= load_smp;
    end
  end

  assign fill = last;
`else
  assign fill = '0;
`endif

  always_comb begin
    tick     = (div_cnt == D_W'(CLK_DIV - 1));
    fall     = tick & sck;
    load     = fall & (p == P_W'(FRAME - 1));
    accept   = src.din_vld & ~hold_full;
    p_nxt    = (p == P_W'(FRAME - 1)) ? '0 : p + 1'b1;
    k_nxt    = (p_nxt >= P_W'(SLOT_W)) ? p_nxt - P_W'(SLOT_W) : p_nxt;
    ws_nxt   = (p_nxt >= P_W'(SLOT_W - 1)) && (p_nxt <= P_W'(FRAME - 2));
    load_smp = hold_full ? hold_data : fill;
    cur_smp  = load ? load_smp : shreg;
    // Walking the MSB mask right selects bit k; for k >= DATA_W it is empty, which gives the zero pad bits.
    sel      = MSB >> k_nxt;
    bit_nxt  = |(cur_smp & sel);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      sck       <= 1'b0;
      ws        <= 1'b0;
      sd        <= 1'b0;
      underrun  <= 1'b0;
      p         <= P_W'(FRAME - 1);
      shreg     <= '0;
      hold_full <= 1'b0;
      hold_data <= '0;
    end else begin
      div_cnt  <= tick ? '0 : div_cnt + 1'b1;
      if (tick) sck <= ~sck;
      underrun <= load & ~hold_full;
      if (fall) begin
        p  <= p_nxt;
        ws <= ws_nxt;
        sd <= bit_nxt;
      end
      if (load) shreg <= load_smp;
      // A frame load and a new accept in the same clk leave hold_full set.
      if (accept) begin
        hold_data <= src.din;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
    end
  end

  assign src.din_rdy = ~hold_full;
endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: two parameter sets run side by side, each checked every clk against a
// frame-level model derived from the edge count since reset.
module tb_i2s_tx;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;

  task automatic chk(input string nm, input int cfg, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cfg%0d t=%0t actual=%h expected=%h", nm, cfg, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int SW      = (g == 0) ? 16 : 32;
    localparam int CD      = (g == 0) ? 4 : 2;
    localparam int FR      = 2 * SW;
    localparam int FD2     = 2 * CD;
    localparam int L       = FR * FD2;
    localparam int T4_EDGE = (7 * FR + 1) * FD2;
    localparam int E_RST   = (29 * FR + SW + 6) * FD2 + 3;

    logic rst, sck, ws, sd, underrun;
    i2s_tx_if #(.DATA_W(16)) bus ();

    i2s_tx #(.DATA_W(16), .SLOT_W(SW), .CLK_DIV(CD)) dut (
      .clk(clk), .rst(rst), .src(bus), .sck(sck), .ws(ws), .sd(sd), .underrun(underrun)
    );

    initial begin : run
      int e, rst_hold, seq_i, n_pre, rate, f, p, k, fi, en, fn, und_cnt;
      bit rst_done, hold_full_m, vld, acc, in_seq, in_pre;
      bit e_sck, e_ws, e_sd, e_und;
      logic [15:0] hold_m, last_m, d, lw, rw;
      logic [15:0] smp_m [64];
      bit          und_m [64];
      logic [15:0] seq [4];
      logic [15:0] lit [6];

      seq = '{16'h0001, 16'h8000, 16'h7FFF, 16'h1234};
      lit = '{16'hA5C3, 16'h0001, 16'h8000, 16'h7FFF, 16'h1234, (HOLD ? 16'h1234 : 16'h0000)};
      rst = 1'b1; bus.din_vld = 1'b0; bus.din = '0;
      e = 0; rst_hold = 3; seq_i = 0; n_pre = 0; rate = 0; und_cnt = 0;
      rst_done = 0; hold_full_m = 0; hold_m = '0; last_m = '0; lw = '0; rw = '0;
      f = 0; p = 0; k = 0; fi = 0;
      for (int i = 0; i < 64; i++) begin smp_m[i] = '0; und_m[i] = 0; end

      for (int cyc = 0; cyc < 36 * 256; cyc++) begin
        @(negedge clk);
        e_sck = ((e / CD) % 2) == 1;
        f = e / FD2;
        e_ws = 0; e_sd = 0; e_und = 0;
        if (f >= 1) begin
          p  = (f - 1) % FR;
          fi = (f - 1) / FR;
          k  = p % SW;
          e_ws = (p >= SW - 1) && (p <= FR - 2);
          if (k < 16) e_sd = smp_m[fi % 64][15 - k];
          e_und = (e % FD2 == 0) && (p == 0) && und_m[fi % 64];
        end
        chk("sck", g, 32'(sck), 32'(e_sck));
        chk("ws", g, 32'(ws), 32'(e_ws));
        chk("sd", g, 32'(sd), 32'(e_sd));
        chk("underrun", g, 32'(underrun), 32'(e_und));
        chk("din_rdy", g, 32'(bus.din_rdy), 32'(!hold_full_m));

        if (!rst_done) begin
          if (underrun) und_cnt++;
          if (f >= 1 && e % FD2 == 0) begin
            if (k < 16) begin
              if (p < SW) lw = {lw[14:0], sd};
              else        rw = {rw[14:0], sd};
            end
            if (p == FR - 1 && fi < 6) begin
              chk("frame_left_lit", g, 32'(lw), 32'(lit[fi]));
              chk("frame_right_lit", g, 32'(rw), 32'(lit[fi]));
            end
          end
          if (e == 5 * L) chk("no_underrun_f0_4", g, und_cnt, 0);
          if (e == (5 * FR + 1) * FD2) chk("underrun_f5_lit", g, 32'(underrun), 1);
          if (e == (5 * FR + 1) * FD2 + 1) chk("underrun_f5_end", g, 32'(underrun), 0);
        end

        if (!rst_done && e == E_RST) begin
          chk("held_before_rst", g, 32'(bus.din_rdy), 0);
          rst = 1'b1; bus.din_vld = 1'b0;
          #1;
          chk("rst_sck", g, 32'(sck), 0);
          chk("rst_ws", g, 32'(ws), 0);
          chk("rst_sd", g, 32'(sd), 0);
          chk("rst_underrun", g, 32'(underrun), 0);
          chk("rst_din_rdy", g, 32'(bus.din_rdy), 1);
          e = 0; hold_full_m = 0; last_m = '0; rst_hold = 3; rst_done = 1;
        end
        if (rst_hold > 0) begin
          rst_hold--;
          if (rst_hold == 0) rst = 1'b0;
        end

        en = e + 1;
        vld = 0; d = '0; in_seq = 0; in_pre = 0;
        if (e % L == 0) rate = $urandom_range(0, 3);
        if (rst) begin
          vld = 0;
        end else if (rst_done || (en > T4_EDGE && e < 27 * L)) begin
          if (!rst_done || e >= FD2) begin
            case (rate)
              0:       vld = 0;
              1:       vld = ($urandom_range(0, 63) == 0);
              2:       vld = ($urandom_range(0, 299) == 0);
              default: vld = 1;
            endcase
            d = 16'($urandom);
          end
        end else if (e == 0) begin
          vld = 1; d = 16'hA5C3;
        end else if (seq_i < 4) begin
          if (e > 20) begin vld = 1; d = seq[seq_i]; in_seq = 1; end
        end else if (en == T4_EDGE) begin
          vld = 1; d = 16'($urandom);
        end else if (e >= 28 * L + FD2 && n_pre < 2) begin
          vld = 1; d = 16'($urandom); in_pre = 1;
        end
        bus.din_vld = vld;
        bus.din     = d;

        if (!rst) begin
          acc = vld && !hold_full_m;
          fn  = en / FD2;
          if (en % FD2 == 0 && fn >= 1 && (fn - 1) % FR == 0) begin
            fi = (fn - 1) / FR;
            und_m[fi % 64] = !hold_full_m;
            if (hold_full_m) begin
              smp_m[fi % 64] = hold_m;
              last_m = hold_m;
            end else begin
              smp_m[fi % 64] = HOLD ? last_m : 16'h0000;
            end
            hold_full_m = 0;
          end
          if (acc) begin
            hold_m = d; hold_full_m = 1;
            if (in_seq) seq_i++;
            if (in_pre) n_pre++;
          end
          e = en;
        end
      end
      n_done++;
    end
  end

  initial begin
    for (int i = 0; i < 60000; i++) begin
      @(posedge clk);
      if (n_done == 2) break;
    end
    if (n_done != 2) begin
      n_chk++; n_fail++;
      $display("FAIL timeout actual=%0d expected=2 finished configs", n_done);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
